// File: rtl/core_boot_pkg.sv
// core_boot_pkg: shared state/cause encodings and default boot addresses for the boot sequencer.
package core_boot_pkg;
  typedef enum logic [1:0] {ST_HOLD = 2'd0, ST_ARM = 2'd1, ST_RUN = 2'd2} seq_state_e;
  typedef enum logic [1:0] {CAUSE_POR = 2'd0, CAUSE_KEY = 2'd1, CAUSE_JTAG = 2'd2, CAUSE_SW = 2'd3} reset_cause_e;
  localparam logic [31:0] DEF_BOOT_ADDR     = 32'h0000_8000;
  localparam logic [31:0] DEF_ALT_BOOT_ADDR = 32'h0000_0000;
  function automatic reset_cause_e pick_cause(input logic jtag, input logic key, input logic sw);
    return jtag ? CAUSE_JTAG : key ? CAUSE_KEY : sw ? CAUSE_SW : CAUSE_POR;
  endfunction
endpackage

// File: rtl/boot_debounce.sv
// boot_debounce: 2-flop synchronizers for key/jtag/boot_sel plus a key debouncer emitting one pulse per press.
module boot_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_rst_n,
  input  logic jtag_reset,
  input  logic boot_sel,
  output logic key_pulse,
  output logic jtag_s,
  output logic boot_sel_s
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [2:0] sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic stable_q, stable_d, pulse_q, pulse_d, diff, done;
  always_comb begin
    diff     = sync2_q[0] != stable_q;
    done     = diff && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    cnt_d    = (diff && !done) ? cnt_q + CW'(1) : '0;
    stable_d = done ? sync2_q[0] : stable_q;
    pulse_d  = done && !sync2_q[0];
  end
  // Reset value treats the key as released so no press is seen out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 3'b001;
      sync2_q  <= 3'b001;
      cnt_q    <= '0;
      stable_q <= 1'b1;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= {boot_sel, jtag_reset, key_rst_n};
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
    end
  end
  assign key_pulse  = pulse_q;
  assign jtag_s     = sync2_q[1];
  assign boot_sel_s = sync2_q[2];
endmodule

// File: rtl/core_boot_sequencer.sv
// core_boot_sequencer: HOLD -> ARM -> RUN core reset/fetch sequencing with cause tracking.
// Define BOOT_SEQ_RESET_COUNT_EN to enable the saturating reset_count counter.
module core_boot_sequencer
  import core_boot_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR       = DEF_BOOT_ADDR,
  parameter logic [31:0] ALT_BOOT_ADDR   = DEF_ALT_BOOT_ADDR,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          HOLD_CYCLES     = 16,
  parameter int          FETCH_DELAY     = 8
) (
  input  logic        CLK_50,
  input  logic        reset_n,
  input  logic        key_rst_n,
  input  logic        jtag_reset,
  input  logic        sw_reset_req,
  input  logic        boot_sel,
  output logic        core_reset_n,
  output logic        fetch_enable,
  output logic [31:0] boot_addr,
  output logic [1:0]  seq_state,
  output logic [1:0]  reset_cause,
  output logic [7:0]  reset_count
);
  seq_state_e   state_q, state_d;
  reset_cause_e cause_q, cause_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [31:0]  addr_q, addr_d;
  logic core_rst_n_q, core_rst_n_d, fetch_q, fetch_d;
  logic key_pulse, jtag_s, boot_sel_s, req, hold_done, arm_done;
  boot_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk       (CLK_50),
    .rst_n     (reset_n),
    .key_rst_n (key_rst_n),
    .jtag_reset(jtag_reset),
    .boot_sel  (boot_sel),
    .key_pulse (key_pulse),
    .jtag_s    (jtag_s),
    .boot_sel_s(boot_sel_s)
  );
  always_comb begin
    req          = key_pulse | jtag_s | sw_reset_req;
    hold_done    = state_q == ST_HOLD && cnt_q == 8'(HOLD_CYCLES - 1);
    arm_done     = state_q == ST_ARM && cnt_q == 8'(FETCH_DELAY - 1);
    state_d      = req ? ST_HOLD : hold_done ? ST_ARM : arm_done ? ST_RUN : state_q;
    cnt_d        = (req || hold_done || arm_done || state_q == ST_RUN) ? 8'd0 : cnt_q + 8'd1;
    cause_d      = req ? pick_cause(jtag_s, key_pulse, sw_reset_req) : cause_q;
    addr_d       = state_q == ST_HOLD ? (boot_sel_s ? ALT_BOOT_ADDR : BOOT_ADDR) : addr_q;
    core_rst_n_d = state_d != ST_HOLD;
    fetch_d      = state_d == ST_RUN;
  end
  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_HOLD;
      cnt_q        <= 8'd0;
      cause_q      <= CAUSE_POR;
      addr_q       <= BOOT_ADDR;
      core_rst_n_q <= 1'b0;
      fetch_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cause_q      <= cause_d;
      addr_q       <= addr_d;
      core_rst_n_q <= core_rst_n_d;
      fetch_q      <= fetch_d;
    end
  end
`ifdef BOOT_SEQ_RESET_COUNT_EN
  logic [7:0] rcnt_q, rcnt_d;
  // A request that lands while already in HOLD only restarts it, so it is not a new entry.
  always_comb rcnt_d = (req && state_q != ST_HOLD && rcnt_q != 8'hff) ? rcnt_q + 8'd1 : rcnt_q;
  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) rcnt_q <= 8'd0;
    else          rcnt_q <= rcnt_d;
  end
  assign reset_count = rcnt_q;
`else
  assign reset_count = 8'd0;
`endif
  assign core_reset_n = core_rst_n_q;
  assign fetch_enable = fetch_q;
  assign boot_addr    = addr_q;
  assign seq_state    = state_q;
  assign reset_cause  = cause_q;
endmodule

// File: tb/tb_core_boot_sequencer.sv
// tb_core_boot_sequencer: randomized self-checking bench for core_boot_sequencer.
module tb_core_boot_sequencer;
  localparam int DEB = 4, HOLD = 16, FD = 8;
  localparam logic [31:0] BA = 32'h0000_8000, ALT = 32'h0000_0000;
`ifdef BOOT_SEQ_RESET_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic CLK_50 = 1'b0, reset_n = 1'b0, key_rst_n = 1'b1, jtag_reset = 1'b0, sw_reset_req = 1'b0, boot_sel = 1'b0;
  logic core_reset_n, fetch_enable;
  logic [31:0] boot_addr;
  logic [1:0] seq_state, reset_cause;
  logic [7:0] reset_count;
  int checks = 0, errors = 0;
  int entries = 0, exp_cause = 0, key_lat = DEB + 3;
  logic [31:0] exp_addr = BA;
  core_boot_sequencer #(.DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .FETCH_DELAY(FD)) dut (
    .CLK_50(CLK_50), .reset_n(reset_n), .key_rst_n(key_rst_n), .jtag_reset(jtag_reset),
    .sw_reset_req(sw_reset_req), .boot_sel(boot_sel), .core_reset_n(core_reset_n),
    .fetch_enable(fetch_enable), .boot_addr(boot_addr), .seq_state(seq_state),
    .reset_cause(reset_cause), .reset_count(reset_count)
  );
  always #10 CLK_50 = ~CLK_50;
  task automatic tick(input int n);
    repeat (n) @(posedge CLK_50);
    #1;
  endtask
  function automatic logic [7:0] exp_rc();
    return CNT_EN ? (entries > 255 ? 8'd255 : 8'(entries)) : 8'd0;
  endfunction
  task automatic wait_run(input string tag);
    int n = 0;
    while (fetch_enable !== 1'b1 && n < 300) begin tick(1); n++; end
    checks++;
    if (fetch_enable !== 1'b1) begin errors++; $display("FAIL %s_run: fetch_enable=%b after %0d cycles, want 1", tag, fetch_enable, n); end
  endtask
  task automatic test_reset;
    int n = 0, m = 0;
    reset_n = 1'b0; tick(3);
    checks++;
    if ({core_reset_n, fetch_enable, seq_state, reset_cause, reset_count, boot_addr} !== {1'b0, 1'b0, 2'd0, 2'd0, 8'd0, BA}) begin
      errors++; $display("FAIL reset_state: got %b %b %0d %0d %0d %h, want 0 0 0 0 0 %h", core_reset_n, fetch_enable, seq_state, reset_cause, reset_count, boot_addr, BA);
    end
    reset_n = 1'b1;
    while (core_reset_n !== 1'b1 && n < 100) begin tick(1); n++; end
    checks++;
    if (n != HOLD) begin errors++; $display("FAIL por_hold_len: got %0d edges, want %0d", n, HOLD); end
    while (fetch_enable !== 1'b1 && m < 100) begin tick(1); m++; end
    checks++;
    if (m != FD) begin errors++; $display("FAIL por_arm_len: got %0d edges, want %0d", m, FD); end
    checks++;
    if ({seq_state, reset_cause, reset_count, boot_addr} !== {2'd2, 2'd0, 8'd0, BA}) begin
      errors++; $display("FAIL por_run: got state %0d cause %0d count %0d addr %h, want 2 0 0 %h", seq_state, reset_cause, reset_count, boot_addr, BA);
    end
  endtask
  task automatic test_key;
    int n = 0, lows = 0, falls = 1;
    logic prev = 1'b0;
    key_rst_n = 1'b0; tick(DEB - 1); key_rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin tick(1); lows += int'(core_reset_n !== 1'b1); end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL key_glitch: got %0d HOLD cycles, want 0", lows); end
    key_rst_n = 1'b0;
    while (core_reset_n === 1'b1 && n < 50) begin tick(1); n++; end
    key_lat = n;
    checks++;
    if (n < DEB + 2 || n > DEB + 4) begin errors++; $display("FAIL key_latency: got %0d edges, want %0d..%0d", n, DEB + 2, DEB + 4); end
    if (n < 10) tick(10 - n);
    key_rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin tick(1); falls += int'(prev === 1'b1 && core_reset_n === 1'b0); prev = core_reset_n; end
    entries++; exp_cause = 1;
    checks++;
    if (falls != 1) begin errors++; $display("FAIL key_press_entries: got %0d, want 1", falls); end
    wait_run("key");
    checks++;
    if (reset_cause !== 2'(exp_cause) || reset_count !== exp_rc()) begin
      errors++; $display("FAIL key_cause_count: got %0d/%0d, want %0d/%0d", reset_cause, reset_count, exp_cause, exp_rc());
    end
  endtask
  task automatic test_jtag_arm;
    int n = 0;
    bit seen = 0;
    sw_reset_req = 1'b1; tick(1); sw_reset_req = 1'b0;
    entries++;
    while (seq_state !== 2'd1 && n < 100) begin tick(1); n++; end
    checks++;
    if (seq_state !== 2'd1) begin errors++; $display("FAIL jtag_reach_arm: state %0d, want 1", seq_state); end
    jtag_reset = 1'b1; n = 0;
    while (n < 500) begin
      tick(1); n++;
      if (n == 40) jtag_reset = 1'b0;
      if (core_reset_n === 1'b0) seen = 1;
      else if (seen) break;
    end
    entries++; exp_cause = 2;
    checks++;
    if (n != 40 + 2 + HOLD || seq_state !== 2'd1) begin
      errors++; $display("FAIL jtag_hold_len: got %0d edges state %0d, want %0d state 1", n, seq_state, 40 + 2 + HOLD);
    end
    wait_run("jtag");
    checks++;
    if (reset_cause !== 2'(exp_cause) || reset_count !== exp_rc()) begin
      errors++; $display("FAIL jtag_cause_count: got %0d/%0d, want %0d/%0d", reset_cause, reset_count, exp_cause, exp_rc());
    end
  endtask
  task automatic test_coincident;
    int n = 0;
    key_rst_n = 1'b0; tick(key_lat - 1);
    sw_reset_req = 1'b1; tick(1); sw_reset_req = 1'b0; key_rst_n = 1'b1;
    entries++; exp_cause = 1;
    checks++;
    if (core_reset_n !== 1'b0) begin errors++; $display("FAIL coincide_entry: core_reset_n=%b, want 0", core_reset_n); end
    while (core_reset_n === 1'b0 && n < 100) begin tick(1); n++; end
    checks++;
    if (n != HOLD) begin errors++; $display("FAIL coincide_hold_len: got %0d, want %0d", n, HOLD); end
    wait_run("coincide");
    checks++;
    if (reset_cause !== 2'(exp_cause) || reset_count !== exp_rc()) begin
      errors++; $display("FAIL coincide_cause_count: got %0d/%0d, want %0d/%0d", reset_cause, reset_count, exp_cause, exp_rc());
    end
  endtask
  task automatic test_back_to_back;
    int n = 1;
    sw_reset_req = 1'b1; tick(1); sw_reset_req = 1'b0;
    tick(5);
    jtag_reset = 1'b1; tick(1); jtag_reset = 1'b0;
    entries++; exp_cause = 2;
    while (core_reset_n === 1'b0 && n < 200) begin tick(1); n++; end
    checks++;
    if (n != 1 + 2 + HOLD) begin errors++; $display("FAIL restart_hold_len: got %0d, want %0d", n, 1 + 2 + HOLD); end
    wait_run("restart");
    checks++;
    if (reset_cause !== 2'(exp_cause) || reset_count !== exp_rc()) begin
      errors++; $display("FAIL restart_cause_count: got %0d/%0d, want %0d/%0d", reset_cause, reset_count, exp_cause, exp_rc());
    end
  endtask
  task automatic test_boot_sel;
    int bad = 0;
    boot_sel = 1'b1; tick(1);
    sw_reset_req = 1'b1; tick(1); sw_reset_req = 1'b0;
    entries++; exp_cause = 3; exp_addr = ALT;
    wait_run("bootsel");
    checks++;
    if (boot_addr !== exp_addr) begin errors++; $display("FAIL bootsel_alt: got %h, want %h", boot_addr, exp_addr); end
    for (int i = 0; i < 20; i++) begin boot_sel = 1'($urandom_range(0, 1)); tick(1); bad += int'(boot_addr !== exp_addr); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bootsel_run_stable: %0d cycles differed from %h", bad, exp_addr); end
  endtask
  task automatic test_random;
    int kind, len, n, m, falls, bad;
    bit entry, seen;
    logic bs, prev;
    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(0, 2); bs = 1'($urandom_range(0, 1)); bad = 0;
      for (int i = 0; i < 4; i++) begin boot_sel = 1'($urandom_range(0, 1)); tick(1); bad += int'(boot_addr !== exp_addr); end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rand%0d_addr_hold: %0d cycles differed from %h", it, bad, exp_addr); end
      boot_sel = bs;
      if (kind == 0) begin
        sw_reset_req = 1'b1; tick(1); sw_reset_req = 1'b0;
        entry = 1; exp_cause = 3; n = 0; m = 0;
        while (core_reset_n === 1'b0 && n < 100) begin tick(1); n++; end
        while (core_reset_n === 1'b1 && fetch_enable === 1'b0 && m < 100) begin tick(1); m++; end
        checks++;
        if (n != HOLD || m != FD) begin errors++; $display("FAIL rand%0d_sw_seq: hold %0d arm %0d, want %0d %0d", it, n, m, HOLD, FD); end
      end else if (kind == 1) begin
        len = $urandom_range(1, DEB + 6); entry = len >= DEB; falls = 0; prev = core_reset_n;
        key_rst_n = 1'b0;
        for (int i = 0; i < len + 40; i++) begin
          tick(1);
          if (i == len - 1) key_rst_n = 1'b1;
          falls += int'(prev === 1'b1 && core_reset_n === 1'b0); prev = core_reset_n;
        end
        if (entry) exp_cause = 1;
        checks++;
        if (falls != int'(entry)) begin errors++; $display("FAIL rand%0d_key_len%0d: got %0d entries, want %0d", it, len, falls, entry); end
      end else begin
        len = $urandom_range(1, 30); entry = 1; exp_cause = 2; n = 0; seen = 0;
        jtag_reset = 1'b1;
        while (n < 500) begin
          tick(1); n++;
          if (n == len) jtag_reset = 1'b0;
          if (core_reset_n === 1'b0) seen = 1;
          else if (seen) break;
        end
        checks++;
        if (n != len + 2 + HOLD) begin errors++; $display("FAIL rand%0d_jtag_len%0d: got %0d edges, want %0d", it, len, n, len + 2 + HOLD); end
      end
      if (entry) begin entries++; exp_addr = bs ? ALT : BA; end
      wait_run("rand");
      checks++;
      if (reset_cause !== 2'(exp_cause) || reset_count !== exp_rc() || boot_addr !== exp_addr) begin
        errors++; $display("FAIL rand%0d_status: got %0d/%0d/%h, want %0d/%0d/%h", it, reset_cause, reset_count, boot_addr, exp_cause, exp_rc(), exp_addr);
      end
    end
  endtask
  task automatic test_saturation;
    for (int i = 0; i < 256; i++) begin
      sw_reset_req = 1'b1; tick(1); sw_reset_req = 1'b0;
      entries++;
      wait_run("sat");
    end
    exp_cause = 3;
    checks++;
    if (reset_count !== (CNT_EN ? 8'd255 : 8'd0) || reset_cause !== 2'(exp_cause)) begin
      errors++; $display("FAIL saturation: got count %0d cause %0d, want %0d 3", reset_count, reset_cause, CNT_EN ? 255 : 0);
    end
  endtask
  initial begin
    test_reset();
    test_key();
    test_jtag_arm();
    test_coincident();
    test_back_to_back();
    test_boot_sel();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
